// File: rtl/run_detector.sv
// Run-length sequence detector: flags when the last RUN_LEN enabled samples of w
// are identical, with polarity/overlap control and a saturating detection counter.
module run_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic             last_bit,
  output logic [LEN_W-1:0] run_len,
  output logic [CNT_W-1:0] det_count
);

  localparam logic [LEN_W-1:0] FULL    = LEN_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN_W-1:0] run_nxt;
  logic             bit_nxt;
  logic             hit;

  // Polarity filter; mode 11 never matches so detection is disabled.
  function automatic logic pol_match(input logic [1:0] m, input logic b);
    logic r;
    r = 1'b0;
    case (m)
      2'b00:   r = 1'b1;
      2'b01:   r = b;
      2'b10:   r = ~b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next run state; a length of 0 marks "no sample since reset".
  always_comb begin
    run_nxt = run_len;
    bit_nxt = last_bit;
    if (en) begin
      if (run_len == '0 || w != last_bit) begin
        run_nxt = LEN_W'(1);
        bit_nxt = w;
      end else if (run_len < FULL) begin
        run_nxt = run_len + LEN_W'(1);
      end else if (!overlap) begin
        run_nxt = LEN_W'(1);
      end
    end
  end

  assign hit = en && (run_nxt == FULL) && pol_match(mode, bit_nxt);
  assign z   = (run_len == FULL) && pol_match(mode, last_bit);

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      run_len   <= '0;
      last_bit  <= 1'b0;
      det_count <= '0;
    end else begin
      run_len  <= run_nxt;
      last_bit <= bit_nxt;
      if (clr)
        det_count <= '0;
      else if (hit && det_count != CNT_MAX)
        det_count <= det_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length sequence detector. It watches a serial input `w` and flags when the last `RUN_LEN` enabled samples are all identical. The run length, polarity mode and overlap behaviour are configurable, and a saturating counter records the number of detections. It generalises the fixed five-state binary/one-hot detectors to arbitrary run length. It sits beside those detectors in the lab top level, driven from switches and buttons, with its outputs driven onto LEDs.

## Interface
- `RUN_LEN`, default 4: samples in a detected run; legal range is 2 to 255.
- `CNT_W`, default 8: width of the detection counter.
- `Clk`, input, 1: rising-edge clock.
- `R`, input, 1: reset; asynchronous and active-high.
- `en`, input, 1: sample enable; `w` is consumed only on edges where `en`=1.
- `w`, input, 1: serial data bit.
- `mode`, input, 2: polarity select.
  - 00: either polarity.
  - 01: runs of 1s only.
  - 10: runs of 0s only.
  - 11: detection disabled.
- `overlap`, input, 1: 1 = overlapping detection; 0 = run restarts after each detection.
- `clr`, input, 1: synchronous clear of `det_count`.
- `z`, output, 1: detection flag.
- `last_bit`, output, 1: value of the current run.
- `run_len`, output, clog2(RUN_LEN+1): current run length, from 0 to RUN_LEN.
- `det_count`, output, CNT_W: saturating detection count.

## Operation
- State is held in registers `run_len` and `last_bit`. `run_len`=0 means no sample has been taken since reset.
- Next-state rule, applied on `Clk` edges with `en`=1:
  - `run_len`==0: `run_len`←1, `last_bit`←`w`.
  - `w`≠`last_bit`: `run_len`←1, `last_bit`←`w`.
  - `w`==`last_bit`, `run_len`<RUN_LEN: `run_len`←`run_len`+1.
  - `w`==`last_bit`, `run_len`==RUN_LEN, `overlap`=1: `run_len` holds at RUN_LEN, which saturates.
  - `w`==`last_bit`, `run_len`==RUN_LEN, `overlap`=0: `run_len`←1, starting a new run of the same bit.
- With `en`=0, all state and `det_count` hold. `clr` still acts.
- `z` = (`run_len`==RUN_LEN) AND polarity match.
  - Polarity match is: `mode`=00; or `mode`=01 and `last_bit`=1; or `mode`=10 and `last_bit`=0.
  - With `mode`=11, `z` is always 0.
  - `z` is combinational from the registered state and the live `mode` input. There is no path from `w` to `z`.
- Detection event: an `en`=1 edge whose next state satisfies the `z` condition, evaluated with `mode` as sampled at that edge.
  - With `overlap`=1, every further matching sample in a run is a new event.
  - With `overlap`=0, events occur at run positions RUN_LEN, 2·RUN_LEN, and so on.
- `det_count` update order, evaluated per edge:
  1. `clr`=1 sets it to 0. Clear wins over a simultaneous event.
  2. Otherwise, on an event, it increments, saturating at 2^CNT_W−1.
- Changing `mode` or `overlap` never alters `run_len` or `last_bit`. It only affects `z` and future updates.

## Timing
- Reset: while `R`=1, independent of `Clk`, `run_len`=0, `last_bit`=0, `det_count`=0 and `z`=0.
  - Reset asserted mid-run discards the run.
  - The first enabled edge after release starts a new run at length 1.
- Latency: `z` rises directly after the edge that samples the RUN_LEN-th equal bit. There is zero added cycles beyond the register.
- `z` falls after the edge that samples a differing bit.
  - With `overlap`=0, `z` also falls after the edge following a detection.
- `det_count` updates on the same edge as the event.
- A `mode` change mid-cycle updates `z` combinationally within the cycle. It does not change `det_count` until the next event.
- There is no handshake. Every `en`=1 edge consumes exactly one bit.

## Test plan
Benches use RUN_LEN=4 and CNT_W=4 unless stated.
- Reset: drive 3 ones, then pulse `R` asynchronously between edges. Outputs go immediately to `run_len`=0, `z`=0 and `det_count`=0. Three more ones then give `run_len`=3, `z`=0.
- Overlap: with `mode`=00 and `overlap`=1, drive `w`=1,1,1,1,1,0 with `en`=1.
  - `z`=1 after edges 4 and 5.
  - `det_count`=2.
  - After edge 6, `z`=0, `run_len`=1 and `last_bit`=0.
- Non-overlap: with `overlap`=0, drive 8 zeros.
  - `z`=1 only after edges 4 and 8.
  - `run_len` after edge 5 is 1.
  - `det_count`=2.
- Mode: with `mode`=01, drive 4 zeros. Expect `z`=0 and `det_count`=0. Then switch `mode` to 10 with no edge: `z`=1 immediately and `det_count` stays 0. Then switch `mode` to 11: `z`=0.
- Enable gating: after 3 ones, hold `en`=0 and toggle `w` for 5 edges. State holds at `run_len`=3. One more enabled 1 gives `z`=1 and `det_count`=1.
- Saturation and clear: 25 overlapping ones give `det_count`=15 held. A `clr` pulse together with a matching sample gives `det_count`=0 and `z`=1. The next matching sample gives `det_count`=1.
